// File: rtl/machine_trap_unit_if.sv
// Redirect/flush handshake between the machine trap unit and fetch.
// The trap unit is the master; fetch acknowledges with redirect_ready.
interface machine_trap_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush_pipeline;

    modport master (
        output redirect_valid,
        output redirect_pc,
        output flush_pipeline,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        input  flush_pipeline,
        output redirect_ready
    );
endinterface

// File: rtl/machine_trap_unit.sv
// M-mode trap entry, MRET return and the machine trap CSR file.
// Traps and returns redirect fetch through a valid/ready handshake.
module machine_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_exception_i,
    input  logic [31:0] exception_program_counter_i,
    input  logic [2:0]  exception_cause_i,
    input  logic [31:0] exception_tval_i,
    input  logic        interrupt_machine_software_i,
    input  logic        interrupt_machine_timer_i,
    input  logic        interrupt_machine_external_i,
    input  logic [31:0] interrupt_program_counter_i,
    input  logic        mret_i,
    input  logic        csr_en_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    machine_trap_unit_if.master redirect
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      state;
    logic        status_mie;
    logic        status_mpie;
    logic [31:0] csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mcause;
    logic [31:0] csr_mtval;
    logic [31:0] csr_mscratch;
    logic        redirect_valid;
    logic        flush_pipeline;
    logic [31:0] redirect_pc;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic [31:0] pending;
    logic [3:0]  irq_code;
    logic [3:0]  exc_code;
    logic        tval_valid;
    logic [31:0] mtvec_base;
    logic [31:0] irq_target;
    logic        exc_take;
    logic        irq_take;
    logic        mret_take;
    logic        trap_event;
    logic [31:0] rdata_raw;
    logic        implemented;
    logic        wr_req;
    logic        csr_we;
    logic [31:0] wr_val;

    // MPP is hardwired to M-mode: only M-mode exists in this core
    assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
    assign mip_val = {20'b0, interrupt_machine_external_i, 3'b0,
                      interrupt_machine_timer_i, 3'b0,
                      interrupt_machine_software_i, 3'b0};
    assign pending = mip_val & csr_mie;

    always_comb begin
        irq_code = 4'd0;
        if (pending[11])
            irq_code = 4'd11;
        else if (pending[3])
            irq_code = 4'd3;
        else if (pending[7])
            irq_code = 4'd7;
    end

    always_comb begin
        exc_code   = 4'd2;
        tval_valid = 1'b0;
        case (exception_cause_i)
            3'd0: begin exc_code = 4'd0; tval_valid = 1'b1; end
            3'd1: exc_code = 4'd2;
            3'd2: exc_code = 4'd3;
            3'd3: begin exc_code = 4'd4; tval_valid = 1'b1; end
            3'd4: begin exc_code = 4'd6; tval_valid = 1'b1; end
            3'd5: exc_code = 4'd11;
            default: exc_code = 4'd2;
        endcase
    end

    assign mtvec_base = {csr_mtvec[31:2], 2'b00};
    assign irq_target = (csr_mtvec[1:0] == 2'b01)
                      ? mtvec_base + {26'b0, irq_code, 2'b00}
                      : mtvec_base;

    assign exc_take   = (state == IDLE) && en_exception_i;
    assign irq_take   = (state == IDLE) && !en_exception_i
                      && status_mie && (|pending);
    assign mret_take  = (state == IDLE) && mret_i
                      && !en_exception_i && !irq_take;
    assign trap_event = exc_take || irq_take || mret_take;

    always_comb begin
        rdata_raw   = 32'h0;
        implemented = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:  rdata_raw = mstatus_val;
            ADDR_MIE:      rdata_raw = csr_mie;
            ADDR_MTVEC:    rdata_raw = csr_mtvec;
            ADDR_MSCRATCH: rdata_raw = csr_mscratch;
            ADDR_MEPC:     rdata_raw = csr_mepc;
            ADDR_MCAUSE:   rdata_raw = csr_mcause;
            ADDR_MTVAL:    rdata_raw = csr_mtval;
            ADDR_MIP:      rdata_raw = mip_val;
            default:       implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never writes
    assign wr_req = csr_en_i && ((csr_op_i == 2'b01)
                  || (csr_op_i[1] && (|csr_wdata_i)));
    assign csr_illegal_o = csr_en_i && (!implemented
                         || ((csr_addr_i == ADDR_MIP) && wr_req));
    assign csr_rdata_o = rdata_raw;
    assign csr_we = wr_req && !csr_illegal_o && !trap_event;

    always_comb begin
        wr_val = rdata_raw;
        case (csr_op_i)
            2'b01:   wr_val = csr_wdata_i;
            2'b10:   wr_val = rdata_raw | csr_wdata_i;
            2'b11:   wr_val = rdata_raw & ~csr_wdata_i;
            default: wr_val = rdata_raw;
        endcase
    end

    assign redirect.redirect_valid = redirect_valid;
    assign redirect.redirect_pc    = redirect_pc;
    assign redirect.flush_pipeline = flush_pipeline;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            status_mie     <= 1'b0;
            status_mpie    <= 1'b0;
            csr_mie        <= 32'h0;
            csr_mtvec      <= RESET_MTVEC;
            csr_mepc       <= 32'h0;
            csr_mcause     <= 32'h0;
            csr_mtval      <= 32'h0;
            csr_mscratch   <= 32'h0;
            redirect_valid <= 1'b0;
            flush_pipeline <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            if (csr_we) begin
                case (csr_addr_i)
                    ADDR_MSTATUS: begin
                        status_mie  <= wr_val[3];
                        status_mpie <= wr_val[7];
                    end
                    ADDR_MIE:      csr_mie <= wr_val & 32'h0000_0888;
                    ADDR_MTVEC:    csr_mtvec <= wr_val[1]
                                 ? {wr_val[31:2], csr_mtvec[1:0]}
                                 : wr_val;
                    ADDR_MSCRATCH: csr_mscratch <= wr_val;
                    ADDR_MEPC:     csr_mepc <= {wr_val[31:2], 2'b00};
                    ADDR_MCAUSE:   csr_mcause <= wr_val;
                    ADDR_MTVAL:    csr_mtval <= wr_val;
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (exc_take) begin
                        csr_mepc    <= {exception_program_counter_i[31:2], 2'b00};
                        csr_mcause  <= {28'b0, exc_code};
                        csr_mtval   <= tval_valid ? exception_tval_i : 32'h0;
                        status_mpie <= status_mie;
                        status_mie  <= 1'b0;
                        redirect_pc <= mtvec_base;
                    end else if (irq_take) begin
                        csr_mepc    <= {interrupt_program_counter_i[31:2], 2'b00};
                        csr_mcause  <= {1'b1, 27'b0, irq_code};
                        csr_mtval   <= 32'h0;
                        status_mpie <= status_mie;
                        status_mie  <= 1'b0;
                        redirect_pc <= irq_target;
                    end else if (mret_take) begin
                        status_mie  <= status_mpie;
                        status_mpie <= 1'b1;
                        redirect_pc <= csr_mepc;
                    end
                    if (trap_event) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        flush_pipeline <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect.redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        flush_pipeline <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_machine_trap_unit.sv
// Directed bench for machine_trap_unit: trap entry, vectoring,
// MRET, redirect stalls, CSR masks and reset during redirect.
module tb_machine_trap_unit;

    localparam logic [31:0] RST_VEC = 32'h0000_0200;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MSCR    = 12'h340;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_en = 1'b0;
    logic [31:0] exc_pc = 32'h0;
    logic [2:0]  exc_cause = 3'd0;
    logic [31:0] exc_tval = 32'h0;
    logic        msi = 1'b0;
    logic        mti = 1'b0;
    logic        mei = 1'b0;
    logic [31:0] irq_pc = 32'h0;
    logic        mret = 1'b0;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    int n_total = 0;
    int n_pass  = 0;

    machine_trap_unit_if rif ();

    machine_trap_unit #(.RESET_MTVEC(RST_VEC)) dut (
        .clk_i                        (clk),
        .rst_i                        (rst),
        .en_exception_i               (exc_en),
        .exception_program_counter_i  (exc_pc),
        .exception_cause_i            (exc_cause),
        .exception_tval_i             (exc_tval),
        .interrupt_machine_software_i (msi),
        .interrupt_machine_timer_i    (mti),
        .interrupt_machine_external_i (mei),
        .interrupt_program_counter_i  (irq_pc),
        .mret_i                       (mret),
        .csr_en_i                     (csr_en),
        .csr_op_i                     (csr_op),
        .csr_addr_i                   (csr_addr),
        .csr_wdata_i                  (csr_wdata),
        .csr_rdata_o                  (csr_rdata),
        .csr_illegal_o                (csr_illegal),
        .redirect                     (rif)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr,
                      input logic [31:0] exp);
        csr_en = 1'b1;
        csr_op = 2'b00;
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
        csr_en = 1'b0;
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd);
        csr_en = 1'b1;
        csr_op = op;
        csr_addr = addr;
        csr_wdata = wd;
        tick();
        csr_en = 1'b0;
        csr_op = 2'b00;
        csr_wdata = 32'h0;
    endtask

    task automatic raise(input logic [2:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval);
        exc_en = 1'b1;
        exc_cause = cause;
        exc_pc = pc;
        exc_tval = tval;
    endtask

    initial begin
        rif.redirect_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'b0, rif.redirect_valid}, 32'h0);
        check("rst_flush", {31'b0, rif.flush_pipeline}, 32'h0);
        check("rst_pc", rif.redirect_pc, 32'h0);
        rst = 1'b1;
        tick();
        rd("rst_mtvec", A_MTVEC, RST_VEC);
        rd("rst_mstatus", A_MSTATUS, 32'h0000_1800);
        rd("rst_mie", A_MIE, 32'h0);

        // load-misaligned exception, direct vector
        csr_do(2'b01, A_MTVEC, 32'h0000_0400);
        raise(3'd3, 32'h100, 32'h2003);
        tick();
        exc_en = 1'b0;
        check("exc_valid", {31'b0, rif.redirect_valid}, 32'h1);
        check("exc_flush", {31'b0, rif.flush_pipeline}, 32'h1);
        check("exc_pc", rif.redirect_pc, 32'h400);
        rd("exc_mepc", A_MEPC, 32'h100);
        rd("exc_mcause", A_MCAUSE, 32'h4);
        rd("exc_mtval", A_MTVAL, 32'h2003);
        rd("exc_mstatus", A_MSTATUS, 32'h0000_1800);
        tick();
        check("exc_done", {31'b0, rif.redirect_valid}, 32'h0);

        // vectored interrupt: external beats timer
        csr_do(2'b01, A_MTVEC, 32'h0000_0401);
        csr_do(2'b01, A_MIE, 32'h0000_0888);
        csr_do(2'b10, A_MSTATUS, 32'h0000_0008);
        rd("irq_mstatus_pre", A_MSTATUS, 32'h0000_1808);
        mti = 1'b1;
        mei = 1'b1;
        irq_pc = 32'h206;
        rd("irq_mip", A_MIP, 32'h880);
        tick();
        check("irq_valid", {31'b0, rif.redirect_valid}, 32'h1);
        check("irq_pc", rif.redirect_pc, 32'h42C);
        rd("irq_mcause", A_MCAUSE, 32'h8000_000B);
        rd("irq_mepc", A_MEPC, 32'h204);
        rd("irq_mtval", A_MTVAL, 32'h0);
        rd("irq_mstatus", A_MSTATUS, 32'h0000_1880);
        mti = 1'b0;
        mei = 1'b0;
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_valid", {31'b0, rif.redirect_valid}, 32'h1);
        check("mret_pc", rif.redirect_pc, 32'h204);
        rd("mret_mstatus", A_MSTATUS, 32'h0000_1888);
        tick();

        // exception and interrupt together: exception first
        mti = 1'b1;
        irq_pc = 32'h500;
        raise(3'd2, 32'h300, 32'hDEAD);
        tick();
        exc_en = 1'b0;
        check("both_pc", rif.redirect_pc, 32'h400);
        rd("both_mcause", A_MCAUSE, 32'h3);
        rd("both_mtval", A_MTVAL, 32'h0);
        rd("both_mepc", A_MEPC, 32'h300);
        tick();
        check("both_masked", {31'b0, rif.redirect_valid}, 32'h0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("both_mret_pc", rif.redirect_pc, 32'h300);
        tick();
        check("both_idle", {31'b0, rif.redirect_valid}, 32'h0);
        tick();
        check("late_irq_valid", {31'b0, rif.redirect_valid}, 32'h1);
        check("late_irq_pc", rif.redirect_pc, 32'h41C);
        rd("late_irq_mcause", A_MCAUSE, 32'h8000_0007);
        rd("late_irq_mepc", A_MEPC, 32'h500);
        mti = 1'b0;
        tick();

        // fetch stalls the redirect; a second exception is ignored
        rif.redirect_ready = 1'b0;
        raise(3'd1, 32'h600, 32'h1234);
        tick();
        exc_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {31'b0, rif.redirect_valid}, 32'h1);
            check("stall_pc", rif.redirect_pc, 32'h400);
            if (i == 1)
                raise(3'd5, 32'h700, 32'h0);
            if (i == 3)
                rif.redirect_ready = 1'b1;
            tick();
            exc_en = 1'b0;
        end
        check("stall_done", {31'b0, rif.redirect_valid}, 32'h0);
        rd("stall_mepc", A_MEPC, 32'h600);
        rd("stall_mcause", A_MCAUSE, 32'h2);
        rd("stall_mtval", A_MTVAL, 32'h0);
        tick();
        check("stall_no_retrap", {31'b0, rif.redirect_valid}, 32'h0);

        // CSR write collides with an ecall: trap wins
        raise(3'd5, 32'h80, 32'h0);
        csr_en = 1'b1;
        csr_op = 2'b01;
        csr_addr = A_MEPC;
        csr_wdata = 32'h999;
        #1;
        check("coll_rdata_old", csr_rdata, 32'h600);
        tick();
        exc_en = 1'b0;
        csr_en = 1'b0;
        csr_op = 2'b00;
        csr_wdata = 32'h0;
        check("coll_pc", rif.redirect_pc, 32'h400);
        rd("coll_mepc", A_MEPC, 32'h80);
        rd("coll_mcause", A_MCAUSE, 32'd11);
        tick();

        // CSR ops and write masks
        csr_do(2'b01, A_MSCR, 32'h0000_A5A5);
        csr_do(2'b10, A_MSCR, 32'h0000_000F);
        csr_do(2'b10, A_MSCR, 32'h0000_0000);
        csr_do(2'b11, A_MSCR, 32'h0000_00A0);
        rd("mscratch_ops", A_MSCR, 32'h0000_A50F);
        csr_do(2'b01, A_MSTATUS, 32'hFFFF_FFFF);
        rd("mstatus_mask", A_MSTATUS, 32'h0000_1888);
        csr_do(2'b01, A_MIE, 32'hFFFF_FFFF);
        rd("mie_mask", A_MIE, 32'h0000_0888);
        csr_do(2'b01, A_MTVEC, 32'h0000_0503);
        rd("mtvec_bad_mode", A_MTVEC, 32'h0000_0501);
        csr_do(2'b01, A_MEPC, 32'h0000_0123);
        rd("mepc_align", A_MEPC, 32'h0000_0120);
        csr_en = 1'b1;
        csr_op = 2'b01;
        csr_addr = A_MIP;
        csr_wdata = 32'h8;
        #1;
        check("mip_write_ill", {31'b0, csr_illegal}, 32'h1);
        csr_op = 2'b00;
        #1;
        check("mip_read_ok", {31'b0, csr_illegal}, 32'h0);
        csr_addr = 12'h7C0;
        #1;
        check("unimpl_ill", {31'b0, csr_illegal}, 32'h1);
        check("unimpl_rdata", csr_rdata, 32'h0);
        csr_en = 1'b0;
        csr_wdata = 32'h0;
        tick();

        // reset asserted while a redirect is pending
        rif.redirect_ready = 1'b0;
        raise(3'd0, 32'h40, 32'h41);
        tick();
        exc_en = 1'b0;
        check("pre_rst_valid", {31'b0, rif.redirect_valid}, 32'h1);
        rd("pre_rst_mtval", A_MTVAL, 32'h41);
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'b0, rif.redirect_valid}, 32'h0);
        check("midrst_flush", {31'b0, rif.flush_pipeline}, 32'h0);
        check("midrst_pc", rif.redirect_pc, 32'h0);
        rd("midrst_mepc", A_MEPC, 32'h0);
        rd("midrst_mstatus", A_MSTATUS, 32'h0000_1800);
        tick();
        rst = 1'b1;
        rif.redirect_ready = 1'b1;
        tick();
        check("post_rst_valid", {31'b0, rif.redirect_valid}, 32'h0);
        rd("post_rst_mtvec", A_MTVEC, RST_VEC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
